// File: rtl/line_cmd_sequencer.sv
// Line-draw command queue feeding the line engine's serial load port.
// Each queued line is loaded as colour, x0, y0, x1, y1, then triggered; the colour load is skipped when it repeats.
module line_cmd_sequencer #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [9:0]    cmd_x0,
  input  logic [9:0]    cmd_y0,
  input  logic [9:0]    cmd_x1,
  input  logic [9:0]    cmd_y1,
  input  logic [31:0]   cmd_color,
  input  logic          LE_ready,
  output logic [31:0]   LE_color,
  output logic [9:0]    LE_point,
  output logic          LE_color_valid,
  output logic          LE_x0_valid,
  output logic          LE_y0_valid,
  output logic          LE_x1_valid,
  output logic          LE_y1_valid,
  output logic          LE_trigger,
  output logic          busy,
  output logic [AW:0]   q_count,
  output logic [15:0]   lines_done,
  output logic [3:0]    dbg_state
);

  // Handshakes: a command transfers on any cycle with cmd_valid && cmd_ready;
  // an engine load or trigger transfers on any cycle its strobe is high, and
  // each strobe is only raised while LE_ready is high.

  typedef enum logic [3:0] {
    S_IDLE,
    S_LD_COL,
    S_LD_X0,
    S_LD_Y0,
    S_LD_X1,
    S_LD_Y1,
    S_TRIG,
    S_WAIT_GO,
    S_WAIT_DONE
  } state_e;

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  state_e        state_q, state_d;
  logic [71:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          cache_v_q;
  logic [31:0]   cache_c_q;
  logic [15:0]   lines_q;

  logic [71:0]   head;
  logic [31:0]   head_color;
  logic [9:0]    head_x0, head_y0, head_x1, head_y1;
  logic          full, push, pop, cache_hit;

  assign head       = mem_q[rd_ptr_q];
  assign head_color = head[71:40];
  assign head_x0    = head[39:30];
  assign head_y0    = head[29:20];
  assign head_x1    = head[19:10];
  assign head_y1    = head[9:0];

  // A full queue still accepts in the cycle the head is popped, so a held
  // command slides in without a bubble.
  assign full      = (count_q == CNT_FULL);
  assign pop       = (state_q == S_TRIG) && LE_ready;
  assign cmd_ready = !full || pop;
  assign push      = cmd_valid && cmd_ready;
  assign cache_hit = cache_v_q && (cache_c_q == head_color);

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_ONE;
    end else if (!push && pop) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      cache_v_q <= 1'b0;
      cache_c_q <= '0;
      lines_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if ((state_q == S_LD_COL) && LE_ready) begin
        cache_v_q <= 1'b1;
        cache_c_q <= head_color;
      end
      if ((state_q == S_WAIT_DONE) && LE_ready) begin
        lines_q <= lines_q + 16'd1;
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    LE_color       = '0;
    LE_point       = '0;
    LE_color_valid = 1'b0;
    LE_x0_valid    = 1'b0;
    LE_y0_valid    = 1'b0;
    LE_x1_valid    = 1'b0;
    LE_y1_valid    = 1'b0;
    LE_trigger     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) state_d = cache_hit ? S_LD_X0 : S_LD_COL;
      end
      S_LD_COL: begin
        LE_color       = head_color;
        LE_color_valid = LE_ready;
        if (LE_ready) state_d = S_LD_X0;
      end
      S_LD_X0: begin
        LE_point    = head_x0;
        LE_x0_valid = LE_ready;
        if (LE_ready) state_d = S_LD_Y0;
      end
      S_LD_Y0: begin
        LE_point    = head_y0;
        LE_y0_valid = LE_ready;
        if (LE_ready) state_d = S_LD_X1;
      end
      S_LD_X1: begin
        LE_point    = head_x1;
        LE_x1_valid = LE_ready;
        if (LE_ready) state_d = S_LD_Y1;
      end
      S_LD_Y1: begin
        LE_point    = head_y1;
        LE_y1_valid = LE_ready;
        if (LE_ready) state_d = S_TRIG;
      end
      S_TRIG: begin
        LE_trigger = LE_ready;
        if (LE_ready) state_d = S_WAIT_GO;
      end
      // The engine keeps LE_ready high for a cycle after the trigger, so
      // completion is only recognised after it has been seen low.
      S_WAIT_GO: begin
        if (!LE_ready) state_d = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (LE_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE) || (count_q != '0);
  assign q_count    = count_q;
  assign lines_done = lines_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_line_cmd_sequencer.sv
// Bench for line_cmd_sequencer: engine model, transaction-level reference model,
// directed latency/full/reset cases, then randomized traffic with engine stalls.
module tb_line_cmd_sequencer;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_x0 = '0, cmd_y0 = '0, cmd_x1 = '0, cmd_y1 = '0;
  logic [31:0] cmd_color = '0;
  logic        LE_ready = 1'b1;
  logic [31:0] LE_color;
  logic [9:0]  LE_point;
  logic        LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger;
  logic        busy;
  logic [AW:0] q_count;
  logic [15:0] lines_done;
  logic [3:0]  dbg_state;

  line_cmd_sequencer #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_x1(cmd_x1), .cmd_y1(cmd_y1),
    .cmd_color(cmd_color), .LE_ready(LE_ready), .LE_color(LE_color), .LE_point(LE_point),
    .LE_color_valid(LE_color_valid), .LE_x0_valid(LE_x0_valid), .LE_y0_valid(LE_y0_valid),
    .LE_x1_valid(LE_x1_valid), .LE_y1_valid(LE_y1_valid), .LE_trigger(LE_trigger),
    .busy(busy), .q_count(q_count), .lines_done(lines_done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] color;
    logic [9:0]  x0, y0, x1, y1;
  } cmd_t;

  // op: 0 colour, 1 x0, 2 y0, 3 x1, 4 y1, 5 trigger
  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] val;
  } step_t;

  int checks = 0;
  int failures = 0;

  // Reference model: the queue of accepted commands, the pending load steps of
  // the line in flight, and whether the engine is being waited on.
  cmd_t        mq[$];
  step_t       steps[$];
  int          phase = 0;
  bit          seen_low = 0;
  bit          cache_v = 0;
  logic [31:0] cache_c = '0;
  logic [15:0] exp_lines = '0;
  bit          model_en = 0;

  bit trig_at_neg = 0;
  bit rst_at_neg = 0;

  int eng_ph = 0;
  int eng_cnt = 0;
  int busy_len = 0;
  bit stall_en = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t state=%0d)", name, act, exp, $time, dbg_state);
    end
  endtask

  function automatic step_t mk(input logic [2:0] op, input logic [31:0] v);
    return {op, v};
  endfunction

  always @(negedge clk) begin
    logic [5:0]  av, ev;
    logic [31:0] ec;
    logic [9:0]  ep;
    step_t       s;
    cmd_t        c;
    int          sz;
    bit          pop_now, acc;

    trig_at_neg = LE_trigger;
    rst_at_neg  = rst;
    av = {LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid, LE_y1_valid, LE_trigger};
    sz = mq.size();
    pop_now = (phase == 1) && (steps[0].op == 3'd5) && LE_ready;

    if (model_en) begin
      ev = '0;
      ec = '0;
      ep = '0;
      if (phase == 1) begin
        s = steps[0];
        if (LE_ready) ev = 6'b100000 >> s.op;
        if (s.op == 3'd0) ec = s.val;
        else if (s.op != 3'd5) ep = s.val[9:0];
      end
      chk("strobes", 64'(av), 64'(ev));
      chk("le_color", 64'(LE_color), 64'(ec));
      chk("le_point", 64'(LE_point), 64'(ep));
      chk("q_count", 64'(q_count), 64'(sz));
      chk("cmd_ready", 64'(cmd_ready), 64'((sz < DEPTH) || pop_now));
      chk("busy", 64'(busy), 64'((phase != 0) || (sz != 0)));
      chk("lines_done", 64'(lines_done), 64'(exp_lines));
      chk("strobe_onehot", 64'($countones(av) <= 1), 64'(1));
    end

    if (rst) begin
      mq.delete();
      steps.delete();
      phase = 0;
      seen_low = 0;
      cache_v = 0;
      cache_c = '0;
      exp_lines = '0;
      model_en = 1;
    end else if (model_en) begin
      acc = cmd_valid && ((sz < DEPTH) || pop_now);
      case (phase)
        0: if (sz != 0) begin
          c = mq[0];
          steps.delete();
          if (!(cache_v && cache_c == c.color)) steps.push_back(mk(3'd0, c.color));
          steps.push_back(mk(3'd1, {22'd0, c.x0}));
          steps.push_back(mk(3'd2, {22'd0, c.y0}));
          steps.push_back(mk(3'd3, {22'd0, c.x1}));
          steps.push_back(mk(3'd4, {22'd0, c.y1}));
          steps.push_back(mk(3'd5, 32'd0));
          phase = 1;
        end
        1: if (LE_ready) begin
          s = steps.pop_front();
          if (s.op == 3'd0) begin
            cache_v = 1;
            cache_c = s.val;
          end
          if (s.op == 3'd5) begin
            void'(mq.pop_front());
            phase = 2;
            seen_low = 0;
          end
        end
        default: begin
          if (!seen_low) begin
            if (!LE_ready) seen_low = 1;
          end else if (LE_ready) begin
            exp_lines = exp_lines + 16'd1;
            phase = 0;
          end
        end
      endcase
      if (acc) mq.push_back({cmd_color, cmd_x0, cmd_y0, cmd_x1, cmd_y1});
    end
  end

  // Engine model: ready for one more cycle after a trigger, then busy, then
  // ready again; random stalls only while it is otherwise idle.
  always @(posedge clk) begin
    #1;
    if (rst_at_neg) begin
      eng_ph = 0;
      LE_ready = 1'b1;
    end else begin
      case (eng_ph)
        0: begin
          if (trig_at_neg) begin
            eng_ph = 1;
            LE_ready = 1'b1;
          end else begin
            LE_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
          end
        end
        1: begin
          eng_ph = 2;
          eng_cnt = (busy_len != 0) ? busy_len : int'($urandom_range(1, 5));
          LE_ready = 1'b0;
        end
        2: begin
          if (eng_cnt > 1) begin
            eng_cnt--;
            LE_ready = 1'b0;
          end else begin
            eng_ph = 3;
            LE_ready = 1'b1;
          end
        end
        default: begin
          eng_ph = 0;
          LE_ready = stall_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input cmd_t c);
    cmd_color = c.color;
    cmd_x0 = c.x0;
    cmd_y0 = c.y0;
    cmd_x1 = c.x1;
    cmd_y1 = c.y1;
  endtask

  task automatic push(input cmd_t c);
    drive(c);
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic obs(input int n, output int col_i, output int trg_i, output logic [31:0] col_v,
                     output logic [9:0] p0, output logic [9:0] p1, output logic [9:0] p2,
                     output logic [9:0] p3);
    col_i = -1;
    trg_i = -1;
    col_v = '0;
    p0 = '0; p1 = '0; p2 = '0; p3 = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (LE_color_valid && col_i < 0) begin
        col_i = i;
        col_v = LE_color;
      end
      if (LE_x0_valid) p0 = LE_point;
      if (LE_y0_valid) p1 = LE_point;
      if (LE_x1_valid) p2 = LE_point;
      if (LE_y1_valid) p3 = LE_point;
      if (LE_trigger && trg_i < 0) trg_i = i;
    end
  endtask

  task automatic wait_idle(input int lim);
    int n = 0;
    @(negedge clk);
    while (busy && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_reached", 64'(busy), 64'(0));
  endtask

  task automatic wait_trig(input int lim);
    int n = 0;
    @(negedge clk);
    while (!LE_trigger && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("trigger_seen", 64'(LE_trigger), 64'(1));
  endtask

  initial begin
    int col_i, trg_i, n;
    logic [31:0] col_v;
    logic [9:0] p0, p1, p2, p3;
    cmd_t c;
    logic [31:0] palette [3];
    palette[0] = 32'h00FF0000;
    palette[1] = 32'h0000FF00;
    palette[2] = 32'h00123456;

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_q_count", 64'(q_count), 64'(0));
    chk("reset_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("reset_busy", 64'(busy), 64'(0));
    chk("reset_lines_done", 64'(lines_done), 64'(0));

    // Single line into an idle engine: exact strobe cycles and values.
    push('{color: 32'h00FF0000, x0: 10'd10, y0: 10'd20, x1: 10'd300, y1: 10'd40});
    obs(10, col_i, trg_i, col_v, p0, p1, p2, p3);
    chk("t1_color_cycle", 64'(col_i), 64'(1));
    chk("t1_color_value", 64'(col_v), 64'h00FF0000);
    chk("t1_x0", 64'(p0), 64'(10));
    chk("t1_y0", 64'(p1), 64'(20));
    chk("t1_x1", 64'(p2), 64'(300));
    chk("t1_y1", 64'(p3), 64'(40));
    chk("t1_trigger_cycle", 64'(trg_i), 64'(6));
    wait_idle(100);
    chk("t1_lines_done", 64'(lines_done), 64'(1));

    // Same colour again: colour load skipped, trigger one cycle earlier.
    push('{color: 32'h00FF0000, x0: 10'd1, y0: 10'd2, x1: 10'd3, y1: 10'd3});
    obs(10, col_i, trg_i, col_v, p0, p1, p2, p3);
    chk("t2_hit_no_color", 64'(col_i), 64'(-1));
    chk("t2_hit_trigger_cycle", 64'(trg_i), 64'(5));
    chk("t2_hit_x0", 64'(p0), 64'(1));
    wait_idle(100);
    push('{color: 32'h0000FF00, x0: 10'd7, y0: 10'd7, x1: 10'd7, y1: 10'd7});
    obs(10, col_i, trg_i, col_v, p0, p1, p2, p3);
    chk("t2_miss_color_cycle", 64'(col_i), 64'(1));
    chk("t2_miss_color_value", 64'(col_v), 64'h0000FF00);
    chk("t2_miss_trigger_cycle", 64'(trg_i), 64'(6));
    wait_idle(100);
    chk("t2_lines_done", 64'(lines_done), 64'(3));

    // Fill the queue behind a long-running line, then push into a full queue.
    busy_len = 30;
    drive('{color: 32'h00123456, x0: 10'd100, y0: 10'd100, x1: 10'd200, y1: 10'd150});
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_trig(20);
    step();
    for (int i = 0; i < 4; i++) begin
      drive('{color: 32'h00123456, x0: 10'(i), y0: 10'(i + 1), x1: 10'(i + 2), y1: 10'(i + 3)});
      cmd_valid = 1'b1;
      step();
    end
    drive('{color: 32'h00123456, x0: 10'd555, y0: 10'd444, x1: 10'd333, y1: 10'd222});
    @(negedge clk);
    chk("t3_full_q_count", 64'(q_count), 64'(4));
    chk("t3_full_not_ready", 64'(cmd_ready), 64'(0));
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ready_on_pop", 64'(cmd_ready), 64'(1));
    chk("t4_pop_cycle", 64'(LE_trigger), 64'(1));
    step();
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("t4_q_count_stays", 64'(q_count), 64'(4));

    // Reset while waiting on the engine with three lines queued.
    wait_trig(100);
    step();
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6_q_count", 64'(q_count), 64'(0));
    chk("t6_strobes", 64'({LE_color_valid, LE_x0_valid, LE_y0_valid, LE_x1_valid,
                           LE_y1_valid, LE_trigger}), 64'(0));
    chk("t6_le_data", 64'({LE_color, LE_point}), 64'(0));
    chk("t6_lines_done", 64'(lines_done), 64'(0));
    chk("t6_busy", 64'(busy), 64'(0));
    busy_len = 0;
    push('{color: 32'h00123456, x0: 10'd9, y0: 10'd8, x1: 10'd7, y1: 10'd6});
    obs(10, col_i, trg_i, col_v, p0, p1, p2, p3);
    chk("t6_color_after_reset", 64'(col_i), 64'(1));
    wait_idle(100);

    // Randomized traffic with engine stalls; the model checks every cycle.
    stall_en = 1;
    for (int i = 0; i < 600; i++) begin
      c.color = palette[$urandom_range(0, 2)];
      c.x0 = 10'($urandom_range(0, 799));
      c.y0 = 10'($urandom_range(0, 599));
      c.x1 = ($urandom_range(0, 7) == 0) ? c.x0 : 10'($urandom_range(0, 799));
      c.y1 = ($urandom_range(0, 7) == 0) ? c.y0 : 10'($urandom_range(0, 599));
      drive(c);
      cmd_valid = ($urandom_range(0, 2) == 0);
      rst = (i == 300);
      step();
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    wait_idle(3000);
    stall_en = 0;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
